// File: rtl/als_ctrl_pkg.sv
// Shared types and constants for the ALS (ALU / RegDesloc / multiplier) sequencer.
package als_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ALU      = 3'd1,
    S_SH_LOAD  = 3'd2,
    S_SH_OP    = 3'd3,
    S_SH_CAP   = 3'd4,
    S_MUL_WAIT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OPC_ALU   = 2'b00,
    OPC_SHIFT = 2'b01,
    OPC_MUL   = 2'b10,
    OPC_RSVD  = 2'b11
  } op_class_t;

  localparam logic [2:0] RD_NOP  = 3'b000;
  localparam logic [2:0] RD_LOAD = 3'b001;
  localparam logic [2:0] RD_SLL  = 3'b010;
  localparam logic [2:0] RD_SRL  = 3'b011;
  localparam logic [2:0] RD_SRA  = 3'b100;
  localparam logic [2:0] RD_ROR  = 3'b101;
  localparam logic [2:0] RD_ROL  = 3'b110;

  localparam int unsigned MULT_TIMEOUT_DEF = 40;
  localparam int unsigned DATA_W           = 32;

  // Only the five real shift/rotate codes may be issued to RegDesloc.
  function automatic logic shift_func_legal(input logic [2:0] func);
    return (func >= RD_SLL) && (func <= RD_ROL);
  endfunction

endpackage

// File: rtl/als_timeout_counter.sv
// Saturating cycle counter with synchronous clear and a terminal-count flag.
module als_timeout_counter #(
  parameter int unsigned TERMINAL = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  localparam int unsigned W = $clog2(TERMINAL + 1);

  logic [W-1:0] count;

  assign terminal_c = (count == W'(TERMINAL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal_c) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/als_sequencer.sv
// Sequences one ALU, shift or multiply operation at a time through the ALS complex
// and returns a 64-bit result with a one-cycle done pulse.
module als_sequencer
  import als_ctrl_pkg::*;
#(
  parameter int unsigned MULT_TIMEOUT = MULT_TIMEOUT_DEF
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [1:0]        op_class,
  input  logic [2:0]        alu_func,
  input  logic [2:0]        shift_func,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi,
  output logic [2:0]        ALU_sel,
  output logic [DATA_W-1:0] oper_A,
  output logic [DATA_W-1:0] oper_B,
  input  logic [DATA_W-1:0] ALU_result,
  output logic              RegDesloc_reset,
  output logic [2:0]        RegDesloc_OP,
  output logic [4:0]        NumberofShifts,
  output logic [DATA_W-1:0] Array,
  input  logic [DATA_W-1:0] Shifted_Array,
  output logic              workMult,
  input  logic [2*DATA_W-1:0] mul,
  input  logic              endMult
);

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              illegal;
  logic              mul_timeout;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [2:0]        alu_func_q;
  logic [2:0]        shift_func_q;
  logic [4:0]        shamt_q;

  assign oper_A          = a_q;
  assign oper_B          = b_q;
  assign Array           = a_q;
  assign ALU_sel         = alu_func_q;
  assign NumberofShifts  = shamt_q;
  assign RegDesloc_reset = reset;

  als_timeout_counter #(
    .TERMINAL (MULT_TIMEOUT)
  ) u_timeout (
    .clk        (Clk),
    .rst        (reset),
    .clear      (accept),
    .enable     (state == S_MUL_WAIT),
    .terminal_c (mul_timeout)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Illegal requests take the ALU slot with error already set, so they share the
  // one-cycle ALU timing while the result stays zero.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          case (op_class_t'(op_class))
            OPC_ALU:   state_next = S_ALU;
            OPC_SHIFT: begin
              if (shift_func_legal(shift_func)) begin
                state_next = S_SH_LOAD;
              end else begin
                illegal    = 1'b1;
                state_next = S_ALU;
              end
            end
            OPC_MUL:   state_next = S_MUL_WAIT;
            default: begin
              illegal    = 1'b1;
              state_next = S_ALU;
            end
          endcase
        end
      end
      S_ALU:      state_next = S_DONE;
      S_SH_LOAD:  state_next = S_SH_OP;
      S_SH_OP:    state_next = S_SH_CAP;
      S_SH_CAP:   state_next = S_DONE;
      S_MUL_WAIT: begin
        if (endMult || mul_timeout) begin
          state_next = S_DONE;
        end
      end
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Handshake and port controls are registered from the upcoming state.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ready        <= 1'b1;
      done         <= 1'b0;
      workMult     <= 1'b0;
      RegDesloc_OP <= RD_NOP;
    end else begin
      ready    <= (state_next == S_IDLE);
      done     <= (state_next == S_DONE);
      workMult <= (state_next == S_MUL_WAIT);
      case (state_next)
        S_SH_LOAD: RegDesloc_OP <= RD_LOAD;
        S_SH_OP:   RegDesloc_OP <= shift_func_q;
        default:   RegDesloc_OP <= RD_NOP;
      endcase
    end
  end

  // Operand latch and result capture.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      alu_func_q   <= '0;
      shift_func_q <= '0;
      shamt_q      <= '0;
      error        <= 1'b0;
      result_lo    <= '0;
      result_hi    <= '0;
    end else begin
      if (accept) begin
        a_q          <= src_a;
        b_q          <= src_b;
        alu_func_q   <= alu_func;
        shift_func_q <= shift_func;
        shamt_q      <= shamt;
        error        <= illegal;
        result_lo    <= '0;
        result_hi    <= '0;
      end
      case (state)
        S_ALU: begin
          if (!error) begin
            result_lo <= ALU_result;
          end
        end
        S_SH_CAP: result_lo <= Shifted_Array;
        S_MUL_WAIT: begin
          if (endMult) begin
            result_hi <= mul[2*DATA_W-1:DATA_W];
            result_lo <= mul[DATA_W-1:0];
          end else if (mul_timeout) begin
            error     <= 1'b1;
            result_hi <= '0;
            result_lo <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_als_sequencer.sv
// Directed bench for als_sequencer with simple ALU, RegDesloc and multiplier models.
module tb_als_sequencer;

  logic        Clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  logic [1:0]  op_class;
  logic [2:0]  alu_func;
  logic [2:0]  shift_func;
  logic [4:0]  shamt;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        done;
  logic        error;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [2:0]  ALU_sel;
  logic [31:0] oper_A;
  logic [31:0] oper_B;
  logic [31:0] ALU_result;
  logic        RegDesloc_reset;
  logic [2:0]  RegDesloc_OP;
  logic [4:0]  NumberofShifts;
  logic [31:0] Array;
  logic [31:0] Shifted_Array;
  logic        workMult;
  logic [63:0] mul;
  logic        endMult;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  als_sequencer #(.MULT_TIMEOUT(40)) dut (
    .Clk            (Clk),
    .reset          (reset),
    .start          (start),
    .ready          (ready),
    .op_class       (op_class),
    .alu_func       (alu_func),
    .shift_func     (shift_func),
    .shamt          (shamt),
    .src_a          (src_a),
    .src_b          (src_b),
    .done           (done),
    .error          (error),
    .result_lo      (result_lo),
    .result_hi      (result_hi),
    .ALU_sel        (ALU_sel),
    .oper_A         (oper_A),
    .oper_B         (oper_B),
    .ALU_result     (ALU_result),
    .RegDesloc_reset(RegDesloc_reset),
    .RegDesloc_OP   (RegDesloc_OP),
    .NumberofShifts (NumberofShifts),
    .Array          (Array),
    .Shifted_Array  (Shifted_Array),
    .workMult       (workMult),
    .mul            (mul),
    .endMult        (endMult)
  );

  // ALU model: 001 add, 010 sub, otherwise and.
  assign ALU_result = (ALU_sel == 3'b001) ? oper_A + oper_B :
                      (ALU_sel == 3'b010) ? oper_A - oper_B : oper_A & oper_B;

  // RegDesloc model: load on 001, shift/rotate on 010..110, one op per edge.
  logic [31:0] sh_reg;
  logic [5:0]  sh_n;
  assign sh_n          = {1'b0, NumberofShifts};
  assign Shifted_Array = sh_reg;
  always_ff @(posedge Clk) begin
    if (RegDesloc_reset) begin
      sh_reg <= '0;
    end else begin
      case (RegDesloc_OP)
        3'b001:  sh_reg <= Array;
        3'b010:  sh_reg <= sh_reg << sh_n;
        3'b011:  sh_reg <= sh_reg >> sh_n;
        3'b100:  sh_reg <= $signed(sh_reg) >>> sh_n;
        3'b101:  sh_reg <= (sh_reg >> sh_n) | (sh_reg << (6'd32 - sh_n));
        3'b110:  sh_reg <= (sh_reg << sh_n) | (sh_reg >> (6'd32 - sh_n));
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request at a sampling point and let the next edge be E0.
  task automatic issue(input logic [1:0] oc, input logic [2:0] af, input logic [2:0] sf,
                       input logic [4:0] sa, input logic [31:0] a, input logic [31:0] b);
    op_class   = oc;
    alu_func   = af;
    shift_func = sf;
    shamt      = sa;
    src_a      = a;
    src_b      = b;
    start      = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded).
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(posedge Clk); #1;
      cyc++;
    end while (!done && cyc < limit);
  endtask

  task automatic run_check(input string tag, input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    wait_done(100, cyc);
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    check({tag, "_result"}, {result_hi, result_lo}, {exp_hi, exp_lo});
    @(posedge Clk); #1;
    check({tag, "_ready_after"}, 64'(ready), 64'(1));
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int cyc;
    int ndone;
    reset = 1'b1; start = 1'b0; op_class = '0; alu_func = '0; shift_func = '0;
    shamt = '0; src_a = '0; src_b = '0; mul = '0; endMult = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_workmult", 64'(workMult), 64'(0));
    check("rst_rd_op", 64'(RegDesloc_OP), 64'(0));
    check("rst_rd_reset", 64'(RegDesloc_reset), 64'(1));
    reset = 1'b0;
    #1;
    check("rst_result", {result_hi, result_lo}, 64'(0));
    check("rst_oper_a", 64'(oper_A), 64'(0));
    @(posedge Clk); #1;

    issue(2'b00, 3'b001, 3'b000, 5'd0, 32'd5, 32'd7);
    check("alu_busy", 64'(ready), 64'(0));
    run_check("alu_add", 1, 1'b0, 32'h0, 32'd12);

    issue(2'b01, 3'b000, 3'b010, 5'd31, 32'h0000_0001, 32'h0);
    check("sll_load_op", 64'(RegDesloc_OP), 64'(3'b001));
    @(posedge Clk); #1;
    check("sll_op", 64'(RegDesloc_OP), 64'(3'b010));
    check("sll_nshift", 64'(NumberofShifts), 64'(31));
    run_check("sll31", 2, 1'b0, 32'h0, 32'h8000_0000);

    issue(2'b01, 3'b000, 3'b100, 5'd4, 32'h8000_0000, 32'h0);
    run_check("sra4", 3, 1'b0, 32'h0, 32'hF800_0000);

    issue(2'b01, 3'b000, 3'b101, 5'd0, 32'h1234_5678, 32'h0);
    run_check("ror0", 3, 1'b0, 32'h0, 32'h1234_5678);

    issue(2'b10, 3'b000, 3'b000, 5'd0, 32'h0, 32'h0);
    check("mul_workmult", 64'(workMult), 64'(1));
    repeat (33) begin
      @(posedge Clk); #1;
    end
    check("mul_still_busy", 64'(done), 64'(0));
    endMult = 1'b1;
    mul     = 64'h0000_0001_FFFF_FFFE;
    wait_done(100, cyc);
    endMult = 1'b0;
    check("mul_done", 64'(done), 64'(1));
    check("mul_latency", 64'(cyc), 64'(1));
    check("mul_result", {result_hi, result_lo}, 64'h0000_0001_FFFF_FFFE);
    check("mul_error", 64'(error), 64'(0));
    check("mul_workmult_low", 64'(workMult), 64'(0));
    @(posedge Clk); #1;
    check("mul_ready_after", 64'(ready), 64'(1));

    issue(2'b10, 3'b000, 3'b000, 5'd0, 32'h0, 32'h0);
    run_check("mul_timeout", 41, 1'b1, 32'h0, 32'h0);

    issue(2'b00, 3'b010, 3'b000, 5'd0, 32'd100, 32'd1);
    run_check("alu_sub_hi_clear", 1, 1'b0, 32'h0, 32'd99);

    issue(2'b11, 3'b001, 3'b000, 5'd0, 32'd5, 32'd7);
    run_check("rsvd_class", 1, 1'b1, 32'h0, 32'h0);

    issue(2'b01, 3'b001, 3'b111, 5'd3, 32'hFFFF_FFFF, 32'h0);
    run_check("bad_shift", 1, 1'b1, 32'h0, 32'h0);

    // start held high while busy: exactly one done.
    op_class = 2'b01; shift_func = 3'b011; shamt = 5'd8; src_a = 32'hABCD_0000;
    start = 1'b1;
    ndone = 0;
    @(posedge Clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (done) begin
        ndone++;
        start = 1'b0;
        check("busy_srl_result", 64'(result_lo), 64'(32'h00AB_CD00));
      end
    end
    start = 1'b0;
    check("busy_one_done", 64'(ndone), 64'(1));

    // Reset while in SH_OP aborts silently.
    issue(2'b01, 3'b000, 3'b010, 5'd2, 32'h0000_00FF, 32'h0);
    @(posedge Clk); #1;
    check("pre_rst_sh_op", 64'(RegDesloc_OP), 64'(3'b010));
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(ready), 64'(1));
    check("mid_rst_rd_op", 64'(RegDesloc_OP), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_result", {result_hi, result_lo}, 64'(0));
    check("mid_rst_rd_reset", 64'(RegDesloc_reset), 64'(1));
    @(posedge Clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      if (done) ndone++;
    end
    check("post_rst_no_done", 64'(ndone), 64'(0));
    issue(2'b00, 3'b010, 3'b000, 5'd0, 32'd10, 32'd3);
    run_check("post_rst_alu", 1, 1'b0, 32'h0, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
